instr_fetch_unit: RTL and testbench

Sequential fetch controller for the RV32IM core's instruction memory. It owns the fetch program counter, drives the word address into the combinational instruction memory every cycle, and buffers returned words with their PCs in a 2-entry prefetch queue. Decode drains the queue through a valid/ready handshake. Execute redirects fetch on taken branches and jumps through a single-cycle redirect pulse.

---
 rtl/instr_fetch_unit.sv | 96 +++++++++
 tb/tb_instr_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch with a 2-entry prefetch queue and a redirect port.
// Optional misaligned-redirect fault state: define FETCH_MISALIGN_CHK_EN.
module instr_fetch_unit #(
  parameter int          ADDR_WIDTH = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  ins_valid,
  input  logic                  ins_ready,
  output logic [31:0]           ins_out,
  output logic [31:0]           ins_pc,
  output logic                  fetch_fault
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  logic [1:0][31:0] q_ins_q, q_ins_d;
  logic [1:0][31:0] q_pc_q, q_pc_d;
  logic [1:0]       count_q, count_d;
  logic [31:0]      fpc_q, fpc_d;
  logic             run, push, pop;

`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic {RUN, FAULT} state_t;
  state_t st_q, st_d;
  assign run         = (st_q == RUN);
  assign fetch_fault = (st_q == FAULT);
`else
  logic unused_rpc_lsbs;
  assign unused_rpc_lsbs = ^redirect_pc[1:0];
  assign run         = 1'b1;
  assign fetch_fault = 1'b0;
`endif

  assign ins_valid = (count_q != 2'd0);
  assign pop       = ins_valid && ins_ready;
  assign push      = run && !redirect_valid && ((count_q != 2'd2) || pop);
  assign imem_addr = fpc_q[ADDR_WIDTH+1:2];
  assign ins_out   = ins_valid ? q_ins_q[0] : NOP;
  assign ins_pc    = ins_valid ? q_pc_q[0]  : 32'd0;

  always_comb begin
    q_ins_d = q_ins_q;
    q_pc_d  = q_pc_q;
    count_d = count_q;
    fpc_d   = fpc_q;
`ifdef FETCH_MISALIGN_CHK_EN
    st_d    = st_q;
`endif
    if (redirect_valid) begin
      count_d = 2'd0;
      fpc_d   = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHK_EN
      st_d    = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
`endif
    end else begin
      if (pop) begin
        q_ins_d[0] = q_ins_q[1];
        q_pc_d[0]  = q_pc_q[1];
        count_d    = count_q - 2'd1;
      end
      // After any pop, count_d is 0 or 1 here, so bit 0 is the tail slot.
      if (push) begin
        q_ins_d[count_d[0]] = imem_data;
        q_pc_d[count_d[0]]  = fpc_q;
        count_d             = count_d + 2'd1;
        fpc_d               = fpc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ins_q <= '0;
      q_pc_q  <= '0;
      count_q <= 2'd0;
      fpc_q   <= RESET_PC;
`ifdef FETCH_MISALIGN_CHK_EN
      st_q    <= RUN;
`endif
    end else begin
      q_ins_q <= q_ins_d;
      q_pc_q  <= q_pc_d;
      count_q <= count_d;
      fpc_q   <= fpc_d;
`ifdef FETCH_MISALIGN_CHK_EN
      st_q    <= st_d;
`endif
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model checked every negedge,
// plus literal checks from directed scenarios and a randomized phase.
module tb_instr_fetch_unit;
  localparam int AW = 5;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          ins_valid, ins_ready;
  logic [31:0]   ins_out, ins_pc;
  logic          fetch_fault;

  logic [31:0] mem [0:(1<<AW)-1];
  assign imem_data = mem[imem_addr];

  instr_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_out(ins_out),
    .ins_pc(ins_pc), .fetch_fault(fetch_fault));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic        m_fault;
  int          n_cmp = 0, n_err = 0;
  logic        chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc   = RPC;
    m_fault = 1'b0;
  endtask

  // One clock edge of the fetch unit as described by its rules.
  task automatic model_step(input logic rdy, input logic rv, input logic [31:0] rpc);
    ent_t e;
    logic pop;
    pop = (mq.size() != 0) && rdy;
    if (rv) begin
      mq.delete();
      m_fpc = {rpc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHK_EN
      m_fault = (rpc[1:0] != 2'b00);
`endif
    end else begin
      if (pop) void'(mq.pop_front());
      if (!m_fault && mq.size() < 2) begin
        e.ins = mem[m_fpc[AW+1:2]];
        e.pc  = m_fpc;
        mq.push_back(e);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    ins_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    if (rst_n) model_step(rdy, rv, rpc);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", 32'(ins_valid), 32'(mq.size() != 0));
      chk("ins_out", ins_out, (mq.size() != 0) ? mq[0].ins : 32'h13);
      chk("ins_pc", ins_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
      chk("imem_addr", 32'(imem_addr), 32'(m_fpc[AW+1:2]));
      chk("fault", 32'(fetch_fault), 32'(m_fault));
    end
  end

  initial begin
    rst_n = 1'b0; ins_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = $urandom;
    mem[0] = 32'h01200093;
    mem[1] = 32'hfc800113;
    model_reset();
    #3;
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_out", ins_out, 32'h13);
    chk("rst_pc", ins_pc, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk_on = 1'b1;
    cyc(0, 0, 0); cyc(0, 0, 0);
    rst_n = 1'b1;

    // Reset release and streaming
    cyc(1, 0, 0);
    chk("s1_valid", 32'(ins_valid), 32'd1);
    chk("s1_out", ins_out, 32'h01200093);
    chk("s1_pc", ins_pc, 32'h0);
    cyc(1, 0, 0);
    chk("s2_pc", ins_pc, 32'h4);
    chk("s2_out", ins_out, 32'hfc800113);
    repeat (3) cyc(1, 0, 0);

    // Async reset between edges with a full queue
    cyc(0, 0, 0); cyc(0, 0, 0);
    #2; rst_n = 1'b0; model_reset(); #1;
    chk("ar_valid", 32'(ins_valid), 32'd0);
    chk("ar_out", ins_out, 32'h13);
    chk("ar_pc", ins_pc, 32'h0);
    chk("ar_addr", 32'(imem_addr), 32'd0);
    cyc(0, 0, 0);
    rst_n = 1'b1;

    // Backpressure from reset
    repeat (5) cyc(0, 0, 0);
    chk("bp_addr", 32'(imem_addr), 32'd2);
    chk("bp_pc0", ins_pc, 32'h0);
    cyc(1, 0, 0);
    chk("bp_pc4", ins_pc, 32'h4);
    cyc(1, 0, 0);
    chk("bp_pc8", ins_pc, 32'h8);

    // Redirect with full queue
    cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(1, 1, 32'h14);
    chk("rd_valid", 32'(ins_valid), 32'd0);
    chk("rd_addr5", 32'(imem_addr), 32'd5);
    cyc(1, 0, 0);
    chk("rd_pc", ins_pc, 32'h14);
    chk("rd_addr6", 32'(imem_addr), 32'd6);
    cyc(1, 0, 0);
    chk("rd_addr7", 32'(imem_addr), 32'd7);

    // Word-address wrap
    cyc(1, 1, 32'h7C);
    chk("wr_addr31", 32'(imem_addr), 32'd31);
    cyc(1, 0, 0);
    chk("wr_pc7c", ins_pc, 32'h7C);
    chk("wr_addr0", 32'(imem_addr), 32'd0);
    cyc(1, 0, 0);
    chk("wr_pc80", ins_pc, 32'h80);
    chk("wr_addr1", 32'(imem_addr), 32'd1);
    cyc(1, 0, 0);
    chk("wr_pc84", ins_pc, 32'h84);

    // Misaligned redirect
    cyc(1, 1, 32'h0A);
    cyc(1, 0, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("ma_fault", 32'(fetch_fault), 32'd1);
    chk("ma_valid", 32'(ins_valid), 32'd0);
    cyc(1, 0, 0);
    chk("ma_valid2", 32'(ins_valid), 32'd0);
    cyc(1, 1, 32'h10);
    cyc(1, 0, 0);
    chk("ma_pc10", ins_pc, 32'h10);
    chk("ma_clr", 32'(fetch_fault), 32'd0);
`else
    chk("ma_pc8", ins_pc, 32'h8);
    chk("ma_nofault", 32'(fetch_fault), 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        r, v;
      logic [31:0] p;
      r = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 1) != 0) ? {$urandom, 2'b00} >> 2 << 2 : $urandom;
      if (i == 300) begin
        #2; rst_n = 1'b0; model_reset();
        cyc(0, 0, 0);
        rst_n = 1'b1;
      end
      cyc(r, v, p);
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
